// File: rtl/control_multicycle.sv
// Multicycle RV32I control FSM: fetch handshake, decode, ALU/memory/writeback sequencing,
// bus-timeout and illegal/system traps, and cycle/instret counters.
module control_multicycle #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter bit SYSTEM_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      instr_q,
    output logic             dmem_req_valid,
    output logic             dmem_req_we,
    input  logic             dmem_req_ready,
    input  logic             dmem_rsp_valid,
    input  logic             branch_taken,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             alu_src_pc,
    output logic [2:0]       ls_funct3,
    output logic [1:0]       wb_sel,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic             pc_we,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXECUTE,
        S_MEM_REQ, S_MEM_WAIT, S_WRITEBACK, S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_COPY_B = 4'd10;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_MISC = 7'b0001111, OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;
    localparam int TW = $clog2(MEM_TIMEOUT) + 1;

    state_t        state, state_nxt;
    logic          run_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_exp, tmo_trap, timed;
    logic          cls_load, cls_store, cls_branch, cls_rdw;

    // Decode of the latched instruction
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [3:0] d_op;
    logic [1:0] d_wb, d_pcsel;
    logic       d_imm, d_pc, d_load, d_store, d_branch, d_rdw, d_ill, d_sys;

    assign opc = instr_q[6:0];
    assign f3  = instr_q[14:12];
    assign f7  = instr_q[31:25];

    always_comb begin
        d_op = ALU_ADD; d_imm = 1'b0; d_pc = 1'b0; d_wb = 2'd0; d_pcsel = 2'd0;
        d_load = 1'b0; d_store = 1'b0; d_branch = 1'b0; d_rdw = 1'b0; d_ill = 1'b0; d_sys = 1'b0;
        case (opc)
            OPC_LUI:   begin d_op = ALU_COPY_B; d_imm = 1'b1; d_rdw = 1'b1; end
            OPC_AUIPC: begin d_imm = 1'b1; d_pc = 1'b1; d_rdw = 1'b1; end
            OPC_JAL:   begin d_imm = 1'b1; d_pc = 1'b1; d_rdw = 1'b1; d_wb = 2'd2; d_pcsel = 2'd1; end
            OPC_JALR: begin
                d_imm = 1'b1; d_rdw = 1'b1; d_wb = 2'd2; d_pcsel = 2'd2;
                d_ill = (f3 != 3'b000);
            end
            // Branch target is PC+imm through the ALU; comparison happens in the datapath
            OPC_BRANCH: begin
                d_imm = 1'b1; d_pc = 1'b1; d_branch = 1'b1;
                d_ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                d_imm = 1'b1; d_load = 1'b1; d_rdw = 1'b1; d_wb = 2'd1;
                d_ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                d_imm = 1'b1; d_store = 1'b1;
                d_ill = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                d_imm = 1'b1; d_rdw = 1'b1;
                case (f3)
                    3'b000: d_op = ALU_ADD;
                    3'b010: d_op = ALU_SLT;
                    3'b011: d_op = ALU_SLTU;
                    3'b100: d_op = ALU_XOR;
                    3'b110: d_op = ALU_OR;
                    3'b111: d_op = ALU_AND;
                    3'b001: begin d_op = ALU_SLL; d_ill = (f7 != F7_BASE); end
                    default: begin
                        d_op  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        d_ill = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                d_rdw = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  d_op = ALU_ADD;
                        3'b001:  d_op = ALU_SLL;
                        3'b010:  d_op = ALU_SLT;
                        3'b011:  d_op = ALU_SLTU;
                        3'b100:  d_op = ALU_XOR;
                        3'b101:  d_op = ALU_SRL;
                        3'b110:  d_op = ALU_OR;
                        default: d_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    d_op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    d_op = ALU_SRA;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_MISC:   d_ill = !(SYSTEM_EN && f3 == 3'b000);
            OPC_SYSTEM: begin
                d_sys = SYSTEM_EN && f3 == 3'b000 && (instr_q[31:20] == 12'h000 || instr_q[31:20] == 12'h001);
                d_ill = !d_sys;
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign timed   = (state == S_FETCH_WAIT) || (state == S_MEM_REQ) || (state == S_MEM_WAIT);
    assign tmo_exp = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

    // Awaited handshake is tested before expiry so a late arrival still wins
    always_comb begin
        state_nxt = state;
        tmo_trap  = 1'b0;
        case (state)
            S_FETCH:      if (imem_req_valid && imem_req_ready) state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (imem_rsp_valid)  state_nxt = S_DECODE;
                else if (tmo_exp)    begin state_nxt = S_HALT; tmo_trap = 1'b1; end
            end
            S_DECODE:     state_nxt = (d_ill || d_sys) ? S_HALT : S_EXECUTE;
            S_EXECUTE:    state_nxt = (cls_load || cls_store) ? S_MEM_REQ : S_WRITEBACK;
            S_MEM_REQ: begin
                if (dmem_req_ready)  state_nxt = S_MEM_WAIT;
                else if (tmo_exp)    begin state_nxt = S_HALT; tmo_trap = 1'b1; end
            end
            S_MEM_WAIT: begin
                if (dmem_rsp_valid)  state_nxt = S_WRITEBACK;
                else if (tmo_exp)    begin state_nxt = S_HALT; tmo_trap = 1'b1; end
            end
            S_WRITEBACK:  state_nxt = S_FETCH;
            default:      state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0; tmo_cnt <= '0; instr_q <= '0;
            alu_op <= ALU_ADD; alu_src_imm <= 1'b0; alu_src_pc <= 1'b0;
            wb_sel <= 2'd0; pc_sel <= 2'd0; trap_cause <= 2'd0;
            cls_load <= 1'b0; cls_store <= 1'b0; cls_branch <= 1'b0; cls_rdw <= 1'b0;
            cycle_count <= '0; instret_count <= '0;
        end else begin
            // Holds off the first fetch request until one edge after reset release
            run_q   <= 1'b1;
            tmo_cnt <= (timed && state_nxt == state) ? tmo_cnt + TW'(1) : '0;
            case (state)
                S_FETCH_WAIT: if (imem_rsp_valid) instr_q <= imem_rsp_data;
                S_DECODE: begin
                    alu_op <= d_op; alu_src_imm <= d_imm; alu_src_pc <= d_pc;
                    wb_sel <= d_wb; pc_sel <= d_pcsel;
                    cls_load <= d_load; cls_store <= d_store; cls_branch <= d_branch; cls_rdw <= d_rdw;
                    if (d_ill)      trap_cause <= 2'd1;
                    else if (d_sys) trap_cause <= 2'd3;
                end
                S_EXECUTE: if (cls_branch) pc_sel <= branch_taken ? 2'd1 : 2'd0;
                default: ;
            endcase
            if (tmo_trap)              trap_cause    <= 2'd2;
            if (state != S_HALT)       cycle_count   <= cycle_count + CNT_W'(1);
            if (state == S_WRITEBACK)  instret_count <= instret_count + CNT_W'(1);
        end
    end

    assign imem_req_valid = run_q && (state == S_FETCH);
    assign dmem_req_valid = (state == S_MEM_REQ);
    assign dmem_req_we    = (state == S_MEM_REQ) && cls_store;
    assign reg_write      = (state == S_WRITEBACK) && cls_rdw;
    assign pc_we          = (state == S_WRITEBACK);
    assign halted         = (state == S_HALT);
    assign ls_funct3      = instr_q[14:12];

endmodule
